// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared encodings, ALU operations and decode helper for the cpu core
// Rev    : 1.0
// ============================================================================
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE   = 6'b000000;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_ADDI    = 6'b001000;

    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;

    localparam logic [2:0] gr0 = 3'd0;
    localparam logic [2:0] gr1 = 3'd1;
    localparam logic [2:0] gr2 = 3'd2;
    localparam logic [2:0] gr3 = 3'd3;
    localparam logic [2:0] gr4 = 3'd4;
    localparam logic [2:0] gr5 = 3'd5;
    localparam logic [2:0] gr6 = 3'd6;
    localparam logic [2:0] gr7 = 3'd7;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_t;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    use_imm;
        logic    use_rt;
        alu_op_t alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Anything not recognised collapses to CTRL_NOP: no register or memory write.
    function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] funct);
        ctrl_t c;
        c = CTRL_NOP;
        case (op)
            OP_RTYPE: begin
                c.reg_write = 1'b1;
                c.use_rt    = 1'b1;
                case (funct)
                    FUNCT_ADD: c.alu_op = ALU_ADD;
                    FUNCT_SUB: c.alu_op = ALU_SUB;
                    FUNCT_AND: c.alu_op = ALU_AND;
                    FUNCT_OR:  c.alu_op = ALU_OR;
                    FUNCT_SLT: c.alu_op = ALU_SLT;
                    default:   c = CTRL_NOP;
                endcase
            end
            OP_LW: begin
                c.reg_write = 1'b1;
                c.mem_read  = 1'b1;
                c.use_imm   = 1'b1;
            end
            OP_SW: begin
                c.mem_write = 1'b1;
                c.use_imm   = 1'b1;
                c.use_rt    = 1'b1;
            end
            OP_ADDI: begin
                c.reg_write = 1'b1;
                c.use_imm   = 1'b1;
            end
            default: c = CTRL_NOP;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_if.sv
`default_nettype none
// ============================================================================
// Module : cpu_if
// Brief  : Instruction and data memory bus between the cpu core and its memories
// Rev    : 1.0
// ============================================================================
interface cpu_if;
    logic [31:0] i_addr;
    logic [31:0] i_datain;
    logic [31:0] d_addr;
    logic [31:0] d_datain;
    logic [31:0] d_dataout;
    logic        d_we;

    modport master (
        output i_addr, d_addr, d_dataout, d_we,
        input  i_datain, d_datain
    );

    modport slave (
        input  i_addr, d_addr, d_dataout, d_we,
        output i_datain, d_datain
    );
endinterface
`default_nettype wire

// File: rtl/cpu_alu.sv
`default_nettype none
// ============================================================================
// Module : cpu_alu
// Brief  : Combinational 32-bit ALU (add, sub, and, or, signed slt)
// Rev    : 1.0
// ============================================================================
module cpu_alu
    import cpu_pkg::*;
(
    input  wire [31:0]   a,
    input  wire [31:0]   b,
    input  wire alu_op_t alu_op,
    output logic [31:0]  result
);

    always_comb begin
        result = a + b;
        case (alu_op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {31'd0, ($signed(a) < $signed(b))};
            default: result = a + b;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu.sv
`default_nettype none
// ============================================================================
// Module : cpu
// Brief  : 5-stage in-order MIPS-subset core (IF, ID, EX, MEM, WB)
// Config : FORWARD_EN adds EX operand forwarding and a load-use interlock
// Rev    : 1.0
// ============================================================================
module cpu
    import cpu_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          NUM_GR   = 8
) (
    input  wire       clock,
    input  wire       reset,
    input  wire       start,
    cpu_if.master     bus
);

    logic [31:0] r_pc, r_instr;
    logic [31:0] r_gr [NUM_GR];

    logic [2:0]  w_rs, w_rt, w_rd, w_dst_id;
    logic [31:0] w_imm, w_rs_val, w_rt_val;
    ctrl_t       w_ctrl_id;
    logic        w_stall, w_wb_we, w_d_we;

    logic [31:0] r_reg_a, r_reg_b, r_imm;
    logic [2:0]  r_dst_ex;
    alu_op_t     r_ex_alu_op;
    logic        r_ex_use_imm, r_ex_reg_write, r_ex_mem_read, r_ex_mem_write;

    logic [31:0] w_op_a, w_op_b, w_alu_b, w_alu_y;

    logic [31:0] r_reg_c, r_store_data;
    logic [2:0]  r_dst_mem;
    logic        r_mem_reg_write, r_mem_mem_read, r_mem_mem_write;

    logic [31:0] r_reg_c1;
    logic [2:0]  r_dst_wb;
    logic        r_wb_reg_write;
    logic        w_unused;

    // Only the low three bits of each register field select a register.
    assign w_rs      = r_instr[23:21];
    assign w_rt      = r_instr[18:16];
    assign w_rd      = r_instr[13:11];
    assign w_imm     = {{16{r_instr[15]}}, r_instr[15:0]};
    assign w_ctrl_id = decode(r_instr[31:26], r_instr[5:0]);
    assign w_dst_id  = w_ctrl_id.use_imm ? w_rt : w_rd;
    assign w_wb_we   = r_wb_reg_write && (r_dst_wb != gr0);
    assign w_unused  = ^{r_instr[25:24], r_instr[20:19], w_ctrl_id.use_rt};

    always_comb begin
        w_rs_val = r_gr[w_rs];
        w_rt_val = r_gr[w_rt];
        if (w_wb_we && r_dst_wb == w_rs) w_rs_val = r_reg_c1;
        if (w_wb_we && r_dst_wb == w_rt) w_rt_val = r_reg_c1;
        if (w_rs == gr0) w_rs_val = '0;
        if (w_rt == gr0) w_rt_val = '0;
    end

`ifdef FORWARD_EN
    logic [2:0] r_rs_ex, r_rt_ex;
    logic       w_uses_rs;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rs_ex <= '0;
            r_rt_ex <= '0;
        end else if (start) begin
            r_rs_ex <= w_rs;
            r_rt_ex <= w_rt;
        end
    end

    // EX/MEM is checked last so the younger result wins.
    always_comb begin
        w_op_a = r_reg_a;
        w_op_b = r_reg_b;
        if (r_wb_reg_write && r_dst_wb != gr0 && r_dst_wb == r_rs_ex) w_op_a = r_reg_c1;
        if (r_wb_reg_write && r_dst_wb != gr0 && r_dst_wb == r_rt_ex) w_op_b = r_reg_c1;
        if (r_mem_reg_write && r_dst_mem != gr0 && r_dst_mem == r_rs_ex) w_op_a = r_reg_c;
        if (r_mem_reg_write && r_dst_mem != gr0 && r_dst_mem == r_rt_ex) w_op_b = r_reg_c;
    end

    assign w_uses_rs = w_ctrl_id.reg_write || w_ctrl_id.mem_write;
    assign w_stall   = r_ex_mem_read && (r_dst_ex != gr0) &&
                       ((w_uses_rs && r_dst_ex == w_rs) ||
                        (w_ctrl_id.use_rt && r_dst_ex == w_rt));
`else
    assign w_op_a  = r_reg_a;
    assign w_op_b  = r_reg_b;
    assign w_stall = 1'b0;
`endif

    assign w_alu_b = r_ex_use_imm ? r_imm : w_op_b;

    cpu_alu u_alu (
        .a      (w_op_a),
        .b      (w_alu_b),
        .alu_op (r_ex_alu_op),
        .result (w_alu_y)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc            <= PC_RESET;
            r_instr         <= '0;
            r_reg_a         <= '0;
            r_reg_b         <= '0;
            r_imm           <= '0;
            r_dst_ex        <= '0;
            r_ex_alu_op     <= ALU_ADD;
            r_ex_use_imm    <= 1'b0;
            r_ex_reg_write  <= 1'b0;
            r_ex_mem_read   <= 1'b0;
            r_ex_mem_write  <= 1'b0;
            r_reg_c         <= '0;
            r_store_data    <= '0;
            r_dst_mem       <= '0;
            r_mem_reg_write <= 1'b0;
            r_mem_mem_read  <= 1'b0;
            r_mem_mem_write <= 1'b0;
            r_reg_c1        <= '0;
            r_dst_wb        <= '0;
            r_wb_reg_write  <= 1'b0;
            for (int i = 0; i < NUM_GR; i++) r_gr[i] <= '0;
        end else if (start) begin
            if (!w_stall) begin
                r_pc    <= r_pc + 32'd4;
                r_instr <= bus.i_datain;
            end
            // A stall turns the ID/EX slot into a bubble by dropping its writes.
            r_reg_a         <= w_rs_val;
            r_reg_b         <= w_rt_val;
            r_imm           <= w_imm;
            r_dst_ex        <= w_dst_id;
            r_ex_alu_op     <= w_ctrl_id.alu_op;
            r_ex_use_imm    <= w_ctrl_id.use_imm;
            r_ex_reg_write  <= w_ctrl_id.reg_write && !w_stall;
            r_ex_mem_read   <= w_ctrl_id.mem_read  && !w_stall;
            r_ex_mem_write  <= w_ctrl_id.mem_write && !w_stall;

            r_reg_c         <= w_alu_y;
            r_store_data    <= w_op_b;
            r_dst_mem       <= r_dst_ex;
            r_mem_reg_write <= r_ex_reg_write;
            r_mem_mem_read  <= r_ex_mem_read;
            r_mem_mem_write <= r_ex_mem_write;

            r_reg_c1        <= r_mem_mem_read ? bus.d_datain : r_reg_c;
            r_dst_wb        <= r_dst_mem;
            r_wb_reg_write  <= r_mem_reg_write;

            if (w_wb_we) r_gr[r_dst_wb] <= r_reg_c1;
        end
    end

    assign w_d_we        = start && r_mem_mem_write;
    assign bus.i_addr    = r_pc;
    assign bus.d_addr    = r_reg_c;
    assign bus.d_we      = w_d_we;
    assign bus.d_dataout = w_d_we ? r_store_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_cpu.sv
`default_nettype none
// ============================================================================
// Module : tb_cpu
// Brief  : Self-checking bench for cpu: directed sequences, ALU vector table,
//          and random programs checked against an instruction-level model
// Rev    : 1.0
// ============================================================================
module tb_cpu;

    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25, F_SLT = 6'h2a, F_BAD = 6'h3f;
    localparam logic [5:0] O_LW  = 6'h23, O_SW  = 6'h2b, O_ADDI = 6'h08, O_BAD = 6'h3f;

    logic clk, rst, start;
    cpu_if bus ();

    cpu dut (.clock(clk), .reset(rst), .start(start), .bus(bus));

    logic [31:0] imem [256];
    logic [31:0] dmem [64];
    logic [31:0] prog [$];
    logic [31:0] m_gr [8];
    logic [31:0] m_mem [64];
    int n_checks = 0;
    int n_fail   = 0;

    assign bus.i_datain = imem[bus.i_addr[9:2]];
    assign bus.d_datain = dmem[bus.d_addr[5:0]];

    always @(posedge clk) if (bus.d_we) dmem[bus.d_addr[5:0]] <= bus.d_dataout;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [5:0] funct, input int rd, input int rs, input int rt);
        return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, funct};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input int rt, input int rs, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    task automatic load_prog();
        for (int i = 0; i < 256; i++) imem[i] = '0;
        foreach (prog[i]) imem[i] = prog[i];
    endtask

    task automatic do_reset();
        start = 1'b0;
        rst   = 1'b1;
        tick();
        rst   = 1'b0;
    endtask

    // Run until n_en enabled edges have occurred; start optionally stutters.
    task automatic run(input int n_en, input bit stutter);
        int en = 0;
        int guard = 0;
        while (en < n_en && guard < 4000) begin
            start = stutter ? ($urandom_range(3) != 0) : 1'b1;
            if (start) en++;
            tick();
            guard++;
        end
        start = 1'b0;
        if (en < n_en) check("run_budget", en, n_en);
    endtask

    // Sequential architectural semantics: one instruction fully completes before the next.
    task automatic model_run();
        logic [31:0] w, a, b, imm, res;
        int rs, rt, rd;
        foreach (prog[k]) begin
            w   = prog[k];
            rs  = int'(w[23:21]);
            rt  = int'(w[18:16]);
            rd  = int'(w[13:11]);
            imm = {{16{w[15]}}, w[15:0]};
            a   = m_gr[rs];
            b   = m_gr[rt];
            if (w[31:26] == 6'b000000) begin
                case (w[5:0])
                    F_ADD: res = a + b;
                    F_SUB: res = a - b;
                    F_AND: res = a & b;
                    F_OR:  res = a | b;
                    F_SLT: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: rd = 0;
                endcase
                if (rd != 0) m_gr[rd] = res;
            end else if (w[31:26] == O_LW) begin
                res = a + imm;
                if (rt != 0) m_gr[rt] = m_mem[res[5:0]];
            end else if (w[31:26] == O_SW) begin
                res = a + imm;
                m_mem[res[5:0]] = b;
            end else if (w[31:26] == O_ADDI) begin
                if (rt != 0) m_gr[rt] = a + imm;
            end
        end
    endtask

    function automatic logic [31:0] rand_ins();
        int k = $urandom_range(9);
        int rs = $urandom_range(31);
        int rt = $urandom_range(31);
        int rd = $urandom_range(31);
        logic [15:0] imm = 16'($urandom);
        case (k)
            0: return r_ins(F_ADD, rd, rs, rt);
            1: return r_ins(F_SUB, rd, rs, rt);
            2: return r_ins(F_AND, rd, rs, rt);
            3: return r_ins(F_OR,  rd, rs, rt);
            4: return r_ins(F_SLT, rd, rs, rt);
            5: return i_ins(O_ADDI, rt, rs, imm);
            6: return i_ins(O_LW, rt, rs, imm);
            7: return i_ins(O_SW, rt, rs, imm);
            8: return r_ins(F_BAD, rd, rs, rt);
            default: return i_ins(O_BAD, rt, rs, imm);
        endcase
    endfunction

    task automatic random_round(input int n, input int gap, input bit stutter);
        prog = {};
        for (int r = 1; r < 8; r++) begin
            prog.push_back(i_ins(O_LW, r, 0, 16'($urandom_range(63))));
            for (int g = 0; g < gap; g++) prog.push_back(32'd0);
        end
        for (int i = 0; i < n; i++) begin
            prog.push_back(rand_ins());
            for (int g = 0; g < gap; g++) prog.push_back(32'd0);
        end
        for (int i = 0; i < 64; i++) begin
            dmem[i]  = $urandom;
            m_mem[i] = dmem[i];
        end
        for (int i = 0; i < 8; i++) m_gr[i] = '0;
        load_prog();
        model_run();
        do_reset();
        run(prog.size() + 2 * n + 20, stutter);
        for (int i = 0; i < 8; i++) check($sformatf("rand_gr%0d", i), dut.r_gr[i], m_gr[i]);
        for (int i = 0; i < 64; i++) check($sformatf("rand_mem%0d", i), dmem[i], m_mem[i]);
    endtask

    typedef struct {
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } alu_vec_t;

    alu_vec_t vecs [11];
    int       we_cnt;
    logic [31:0] we_addr, we_data;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 64; i++) dmem[i] = '0;

        vecs[0]  = '{F_ADD, 32'd7,          32'd5,          32'd12};
        vecs[1]  = '{F_ADD, 32'hffff_ffff,  32'd1,          32'd0};
        vecs[2]  = '{F_SUB, 32'd5,          32'd7,          32'hffff_fffe};
        vecs[3]  = '{F_SUB, 32'h8000_0000,  32'd1,          32'h7fff_ffff};
        vecs[4]  = '{F_AND, 32'hf0f0_f0f0,  32'hff00_ff00,  32'hf000_f000};
        vecs[5]  = '{F_OR,  32'hf0f0_f0f0,  32'h0f0f_0000,  32'hffff_f0f0};
        vecs[6]  = '{F_SLT, 32'hffff_ffff,  32'd1,          32'd1};
        vecs[7]  = '{F_SLT, 32'd1,          32'hffff_ffff,  32'd0};
        vecs[8]  = '{F_SLT, 32'h8000_0000,  32'h7fff_ffff,  32'd1};
        vecs[9]  = '{F_SLT, 32'd5,          32'd5,          32'd0};
        vecs[10] = '{F_BAD, 32'd3,          32'd4,          32'd0};

        // Program shared by the idle, store and mid-pipeline reset sequences.
        prog = {};
        prog.push_back(i_ins(O_LW, 1, 0, 16'd1));
        prog.push_back(i_ins(O_LW, 2, 0, 16'd2));
        prog.push_back(32'd0);
        prog.push_back(32'd0);
        prog.push_back(r_ins(F_ADD, 3, 1, 2));
        prog.push_back(32'd0);
        prog.push_back(32'd0);
        prog.push_back(i_ins(O_SW, 3, 0, 16'd8));
        prog.push_back(i_ins(O_ADDI, 0, 0, 16'd7));
        prog.push_back(i_ins(O_ADDI, 4, 0, 16'hffff));
        prog.push_back(i_ins(O_ADDI, 5, 0, 16'd1));
        prog.push_back(32'd0);
        prog.push_back(32'd0);
        prog.push_back(r_ins(F_SLT, 6, 4, 5));
        load_prog();
        dmem[1] = 32'h0000_00ab;
        dmem[2] = 32'h0000_3c00;

        do_reset();
        repeat (3) tick();
        check("idle_pc", dut.r_pc, 32'd0);
        check("idle_instr", dut.r_instr, 32'd0);
        check("idle_d_we", {31'd0, bus.d_we}, 32'd0);
        check("idle_d_addr", bus.d_addr, 32'd0);
        for (int i = 0; i < 8; i++) check($sformatf("idle_gr%0d", i), dut.r_gr[i], 32'd0);

        // Single load, cycle by cycle.
        start = 1'b1;
        tick();
        check("lw_instr_E1", dut.r_instr, i_ins(O_LW, 1, 0, 16'd1));
        tick();
        tick();
        check("lw_mem_d_addr", bus.d_addr, 32'd1);
        check("lw_mem_d_we", {31'd0, bus.d_we}, 32'd0);
        tick();
        check("lw_gr1_E4", dut.r_gr[1], 32'd0);
        tick();
        check("lw_gr1_E5", dut.r_gr[1], 32'h0000_00ab);

        // Rest of the program, watching the store strobe every cycle.
        we_cnt = 0;
        we_addr = '0;
        we_data = '0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.d_we) begin
                we_cnt++;
                we_addr = bus.d_addr;
                we_data = bus.d_dataout;
            end
        end
        start = 1'b0;
        check("add_gr3", dut.r_gr[3], 32'h0000_3cab);
        check("sw_count", we_cnt, 32'd1);
        check("sw_addr", we_addr, 32'd8);
        check("sw_data", we_data, 32'h0000_3cab);
        check("sw_mem", dmem[8], 32'h0000_3cab);
        check("addi_gr0", dut.r_gr[0], 32'd0);
        check("slt_gr6", dut.r_gr[6], 32'd1);

        // Reset in the middle of a run, with start still high.
        do_reset();
        run(9, 1'b0);
        check("prereset_gr1", dut.r_gr[1], 32'h0000_00ab);
        start = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        check("rst_pc", dut.r_pc, 32'd0);
        check("rst_instr", dut.r_instr, 32'd0);
        check("rst_reg_a", dut.r_reg_a, 32'd0);
        check("rst_reg_b", dut.r_reg_b, 32'd0);
        check("rst_reg_c", dut.r_reg_c, 32'd0);
        check("rst_reg_c1", dut.r_reg_c1, 32'd0);
        check("rst_d_out", bus.d_dataout, 32'd0);
        check("rst_gr1", dut.r_gr[1], 32'd0);
        check("rst_gr2", dut.r_gr[2], 32'd0);

        foreach (vecs[v]) begin
            prog = {};
            prog.push_back(i_ins(O_LW, 1, 0, 16'd0));
            prog.push_back(i_ins(O_LW, 2, 0, 16'd4));
            prog.push_back(32'd0);
            prog.push_back(32'd0);
            prog.push_back(r_ins(vecs[v].funct, 3, 1, 2));
            prog.push_back(32'd0);
            prog.push_back(32'd0);
            prog.push_back(i_ins(O_SW, 3, 0, 16'd12));
            load_prog();
            dmem[0]  = vecs[v].a;
            dmem[4]  = vecs[v].b;
            dmem[12] = 32'hdead_beef;
            do_reset();
            run(14, 1'b0);
            check($sformatf("vec%0d_gr3", v), dut.r_gr[3], vecs[v].exp);
            check($sformatf("vec%0d_mem", v), dmem[12], vecs[v].exp);
        end

`ifdef FORWARD_EN
        prog = {};
        prog.push_back(i_ins(O_ADDI, 1, 0, 16'd5));
        prog.push_back(r_ins(F_SUB, 2, 1, 0));
        prog.push_back(i_ins(O_LW, 4, 0, 16'd0));
        prog.push_back(r_ins(F_ADD, 5, 4, 4));
        load_prog();
        dmem[0] = 32'd10;
        do_reset();
        start = 1'b1;
        repeat (5) tick();
        check("fwd_stall_pc", dut.r_pc, 32'd16);
        tick();
        check("fwd_sub_gr2", dut.r_gr[2], 32'd5);
        repeat (2) tick();
        check("fwd_gr5_E8", dut.r_gr[5], 32'd0);
        tick();
        check("fwd_gr5_E9", dut.r_gr[5], 32'd20);
        start = 1'b0;
        random_round(40, 0, 1'b1);
`endif

        random_round(40, 2, 1'b0);
        random_round(40, 2, 1'b1);
        random_round(40, 2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu.md
Name: cpu

Overview:
- 32-bit, 5-stage in-order pipelined MIPS-subset CPU core: IF, ID, EX, MEM, WB.
- Fetches from an external instruction memory and performs loads/stores on an external data memory.
- Holds an 8-entry general register file.
- Sits below the SoC top-level; both memories are external and behave as combinational-read memories.

Parameters:
- PC_RESET, 32'h0000_0000, PC value after reset.
- NUM_GR, 8, number of general registers; index is instruction field bits [2:0].

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  run enable; 0 freezes the whole pipeline.
- i_addr  output  32  instruction address (equals pc).
- i_datain  input  32  instruction word for i_addr.
- d_addr  output  32  data-memory byte address.
- d_datain  input  32  load data for d_addr.
- d_dataout  output  32  store data.
- d_we  output  1  data-memory write strobe.

Behaviour:
- Reset (clock edge with reset=1):
  - pc=PC_RESET.
  - instr, reg_A, reg_B, reg_C, reg_C1 and all control pipeline registers cleared.
  - gr[0..7] cleared.
  - Outputs then: d_we=0, d_dataout=0, d_addr=0.
  - reset has priority over start and can be asserted mid-operation.
- start=0 with reset=0: every register holds its value. d_we is forced to 0.
- Pipeline registers:
  - IF/ID: instr.
  - ID/EX: reg_A (rs value), reg_B (rt value), sign-extended immediate, destination index, control.
  - EX/MEM: reg_C (ALU result / address), store data, control.
  - MEM/WB: reg_C1 (load data or ALU result), control.
- IF: instr<=i_datain; pc<=pc+4.
- Instruction fields: op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0].
- R-type (op 000000):
  - funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed, result 0/1).
  - Destination rd.
  - All arithmetic is 32-bit wrap-around; overflow is ignored.
- I-type, destination rt, imm sign-extended to 32 bits:
  - op 100011 lw: gr[rt]<=mem[gr[rs]+imm].
  - op 101011 sw: mem[gr[rs]+imm]<=gr[rt].
  - op 001000 addi: gr[rt]<=gr[rs]+imm.
- Undefined opcodes/functs, and the all-zero word, execute as NOP: no register or memory write.
- gr[0] always reads 0; writes to it are discarded.
- Register file read is combinational in ID, with write-through: a WB write to the same index in the same cycle is visible to ID.
- MEM stage:
  - d_addr=reg_C, combinational.
  - lw: reg_C1<=d_datain at the MEM-stage edge.
  - sw: d_we=1 and d_dataout=store data for exactly that cycle.
- Latency: an instruction captured into instr at edge N reaches reg_A/reg_B at N+1, reg_C at N+2, reg_C1 at N+3, and gr at N+4.
- No branches/jumps. No stalls other than start=0.

Optional Feature:
- Macro FORWARD_EN.
- Defined:
  - EX operand muxes take EX/MEM (reg_C) or MEM/WB (reg_C1) results when the destination matches rs/rt and is nonzero; EX/MEM has priority.
  - Load-use hazard: one-cycle interlock. pc and instr hold, and a bubble is inserted into ID/EX.
- Undefined:
  - No forwarding and no interlock.
  - Software places at least 2 independent instructions/NOPs between a producer and its consumer (the write-through register file covers the third slot).

Decomposition:
- Package cpu_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_ADDI);
  - funct constants;
  - ALU-operation enum;
  - register-index constants gr0..gr7.
- One sub-module, cpu_alu: combinational, 32-bit a/b, alu_op in, result out.
- The register file stays inline.

Test Plan:
- Reset, then idle with start=0 for 3 cycles -> pc=0, all gr=0, d_we=0.
- lw gr1,1(gr0) with d_datain=32'h0000_00ab during its MEM cycle -> d_addr=1 in MEM, gr1=32'h0000_00ab four edges after capture.
- lw gr2,2(gr0) with d_datain=32'h0000_3c00, two NOPs, then add gr3,gr1,gr2 -> gr3=32'h0000_3cab.
- FORWARD_EN: addi gr1,gr0,5 immediately followed by sub gr2,gr1,gr0 -> gr2=5 with no inserted NOPs. lw followed by a dependent add -> one stall cycle, correct sum.
- sw gr3,8(gr0) with gr3=32'h0000_3cab -> one cycle of d_we=1, d_addr=8, d_dataout=32'h0000_3cab.
- addi gr0,gr0,7 -> gr0 stays 0. slt with gr1=-1 and gr2=1 -> result 1. Reset asserted mid-pipeline -> all state 0 on the next edge.
